// File: rtl/game_state_ctrl.sv
// Frame-rate game supervisor: play/hit/over FSM, saturating BCD score and high score,
// plus a one-frame round restart pulse for the collision and motion stages.
module game_state_ctrl #(
    parameter logic [3:0] MET_PTS     = 4'd1,
    parameter logic [3:0] STAR_PTS    = 4'd5,
    parameter logic [5:0] HIT_FRAMES  = 6'd30,
    parameter logic [7:0] OVER_FRAMES = 8'd120
) (
    input  logic        v_sync,
    input  logic        rst,
    input  logic        start_btn,
    input  logic [1:0]  lives,
    input  logic        m1_alive,
    input  logic        m2_alive,
    input  logic        m3_alive,
    input  logic        s1_alive,
    input  logic        s2_alive,
    output logic [1:0]  state,
    output logic        play_en,
    output logic        round_rst,
    output logic        flash,
    output logic [11:0] score,
    output logic [11:0] hi_score
);

    typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StHit = 2'd2, StOver = 2'd3} st_e;

    st_e        st_q;
    logic [2:0] prev_met;
    logic [1:0] prev_star;
    logic [1:0] prev_lives;
    logic       prev_btn;
    logic [5:0] hit_cnt;
    logic [7:0] over_cnt;
    logic [1:0] flash_sub;

    logic [1:0]  met_cnt, star_cnt;
    logic [5:0]  inc, rem;
    logic [3:0]  inc_tens, inc_ones;
    logic [4:0]  d0, d1, d2;
    logic [11:0] score_sum, score_next;
    logic        hit_ev, over_ev, btn_rise;

    assign state = st_q;

    always_comb begin
        met_cnt  = 2'(prev_met[2] & ~m1_alive) + 2'(prev_met[1] & ~m2_alive)
                 + 2'(prev_met[0] & ~m3_alive);
        star_cnt = 2'(prev_star[1] & ~s1_alive) + 2'(prev_star[0] & ~s2_alive);
        inc      = 6'(met_cnt) * 6'(MET_PTS) + 6'(star_cnt) * 6'(STAR_PTS);
        // Split the binary increment (at most 45) into BCD tens and ones.
        rem      = inc;
        inc_tens = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (rem >= 6'd10) begin
                rem      = rem - 6'd10;
                inc_tens = inc_tens + 4'd1;
            end
        end
        inc_ones = rem[3:0];
        d0 = {1'b0, score[3:0]} + {1'b0, inc_ones};
        d1 = {1'b0, score[7:4]} + {1'b0, inc_tens};
        if (d0 > 5'd9) begin
            d0 = d0 - 5'd10;
            d1 = d1 + 5'd1;
        end
        d2 = {1'b0, score[11:8]};
        if (d1 > 5'd9) begin
            d1 = d1 - 5'd10;
            d2 = d2 + 5'd1;
        end
        score_sum  = (d2 > 5'd9) ? 12'h999 : {d2[3:0], d1[3:0], d0[3:0]};
        score_next = (st_q == StPlay || st_q == StHit) ? score_sum : score;
        hit_ev     = lives < prev_lives;
        over_ev    = hit_ev && (lives == 2'd0);
        btn_rise   = start_btn & ~prev_btn;
    end

    always_ff @(posedge v_sync or posedge rst) begin
        if (rst) begin
            st_q       <= StIdle;
            play_en    <= 1'b0;
            round_rst  <= 1'b0;
            flash      <= 1'b0;
            score      <= 12'h000;
            hi_score   <= 12'h000;
            prev_met   <= 3'b111;
            prev_star  <= 2'b11;
            prev_lives <= 2'd2;
            prev_btn   <= 1'b0;
            hit_cnt    <= 6'd0;
            over_cnt   <= 8'd0;
            flash_sub  <= 2'd0;
        end else begin
            prev_met   <= {m1_alive, m2_alive, m3_alive};
            prev_star  <= {s1_alive, s2_alive};
            prev_lives <= lives;
            prev_btn   <= start_btn;
            round_rst  <= 1'b0;
            score      <= score_next;
            unique case (st_q)
                StIdle: begin
                    if (btn_rise) begin
                        st_q      <= StPlay;
                        play_en   <= 1'b1;
                        round_rst <= 1'b1;
                        score     <= 12'h000;
                    end
                end
                StPlay, StHit: begin
                    if (over_ev) begin
                        // Capture uses the score including this frame's increment.
                        st_q     <= StOver;
                        play_en  <= 1'b0;
                        flash    <= 1'b0;
                        over_cnt <= OVER_FRAMES;
                        if (score_next > hi_score) hi_score <= score_next;
                    end else if (hit_ev) begin
                        st_q    <= StHit;
                        hit_cnt <= HIT_FRAMES;
                        if (st_q == StPlay) begin
                            flash_sub <= 2'd0;
                            flash     <= 1'b0;
                        end else begin
                            flash_sub <= flash_sub + 2'd1;
                            if (flash_sub == 2'd3) flash <= ~flash;
                        end
                    end else if (st_q == StHit) begin
                        if (hit_cnt <= 6'd1) begin
                            st_q    <= StPlay;
                            hit_cnt <= 6'd0;
                            flash   <= 1'b0;
                        end else begin
                            hit_cnt   <= hit_cnt - 6'd1;
                            flash_sub <= flash_sub + 2'd1;
                            if (flash_sub == 2'd3) flash <= ~flash;
                        end
                    end
                end
                StOver: begin
                    if (over_cnt != 8'd0) begin
                        over_cnt <= over_cnt - 8'd1;
                    end else if (btn_rise) begin
                        st_q      <= StPlay;
                        play_en   <= 1'b1;
                        round_rst <= 1'b1;
                        score     <= 12'h000;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: vector table for the opening frames, then
// hand-written sequences for hit/over timing, BCD saturation and async reset.
module tb_game_state_ctrl;

    logic        v_sync = 1'b0;
    logic        rst;
    logic        start_btn;
    logic [1:0]  lives;
    logic        m1_alive, m2_alive, m3_alive, s1_alive, s2_alive;
    logic [1:0]  state;
    logic        play_en, round_rst, flash;
    logic [11:0] score, hi_score;

    int checks   = 0;
    int failures = 0;
    int model    = 0;

    game_state_ctrl dut (
        .v_sync    (v_sync),
        .rst       (rst),
        .start_btn (start_btn),
        .lives     (lives),
        .m1_alive  (m1_alive),
        .m2_alive  (m2_alive),
        .m3_alive  (m3_alive),
        .s1_alive  (s1_alive),
        .s2_alive  (s2_alive),
        .state     (state),
        .play_en   (play_en),
        .round_rst (round_rst),
        .flash     (flash),
        .score     (score),
        .hi_score  (hi_score)
    );

    always #5 v_sync = ~v_sync;

    typedef struct {
        logic        btn;
        logic [1:0]  lv;
        logic [4:0]  alive;
        logic [1:0]  exp_state;
        logic        exp_play;
        logic        exp_rr;
        logic [11:0] exp_score;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int d);
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic step();
        @(posedge v_sync);
        #1;
    endtask

    task automatic set_alive(input logic [4:0] a);
        {m1_alive, m2_alive, m3_alive, s1_alive, s2_alive} = a;
    endtask

    // One frame with the given alive flags; add is the points the flags' falls are worth.
    task automatic frame(input logic [4:0] a, input int add);
        set_alive(a);
        step();
        model = (model + add > 999) ? 999 : model + add;
        chk("score", 32'(score), 32'(to_bcd(model)));
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd2, 5'b11111, 2'd1, 1'b1, 1'b1, 12'h000};
        vecs[1] = '{1'b1, 2'd2, 5'b11111, 2'd1, 1'b1, 1'b0, 12'h000};
        vecs[2] = '{1'b0, 2'd2, 5'b01111, 2'd1, 1'b1, 1'b0, 12'h001};
        vecs[3] = '{1'b0, 2'd2, 5'b11101, 2'd1, 1'b1, 1'b0, 12'h006};
        vecs[4] = '{1'b0, 2'd2, 5'b11111, 2'd1, 1'b1, 1'b0, 12'h006};
        vecs[5] = '{1'b0, 2'd2, 5'b10000, 2'd1, 1'b1, 1'b0, 12'h018};
        vecs[6] = '{1'b0, 2'd2, 5'b11111, 2'd1, 1'b1, 1'b0, 12'h018};
        vecs[7] = '{1'b0, 2'd2, 5'b00000, 2'd1, 1'b1, 1'b0, 12'h031};
        vecs[8] = '{1'b0, 2'd2, 5'b11111, 2'd1, 1'b1, 1'b0, 12'h031};

        rst = 1'b1;
        start_btn = 1'b0;
        lives = 2'd2;
        set_alive(5'b11111);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_score", 32'(score), 32'h000);
            chk("idle_play_en", 32'(play_en), 32'd0);
            chk("idle_round_rst", 32'(round_rst), 32'd0);
        end
        chk("idle_hi", 32'(hi_score), 32'h000);

        for (int i = 0; i < 9; i++) begin
            start_btn = vecs[i].btn;
            lives     = vecs[i].lv;
            set_alive(vecs[i].alive);
            step();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_play_en", i), 32'(play_en), 32'(vecs[i].exp_play));
            chk($sformatf("vec%0d_round_rst", i), 32'(round_rst), 32'(vecs[i].exp_rr));
            chk($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
        end
        model = 31;

        for (int i = 0; i < 5; i++) begin
            frame(5'b00000, 13);
            frame(5'b11111, 0);
        end
        for (int i = 0; i < 2; i++) begin
            frame(5'b01111, 1);
            frame(5'b11111, 0);
        end
        chk("score_098", 32'(score), 32'h098);
        frame(5'b01110, 6);
        chk("score_104", 32'(score), 32'h104);
        frame(5'b11111, 0);

        // Lose a life: 30 frames of HIT with flash toggling every 4 frames.
        lives = 2'd1;
        for (int k = 0; k < 30; k++) begin
            step();
            chk($sformatf("hit%0d_state", k), 32'(state), 32'd2);
            chk($sformatf("hit%0d_flash", k), 32'(flash), 32'((k / 4) % 2));
            chk($sformatf("hit%0d_play_en", k), 32'(play_en), 32'd1);
        end
        step();
        chk("hit_exit_state", 32'(state), 32'd1);
        chk("hit_exit_flash", 32'(flash), 32'd0);
        chk("hit_exit_score", 32'(score), 32'h104);

        // Last life lost with a same-frame meteor; button pressed and held from entry.
        lives = 2'd0;
        start_btn = 1'b1;
        set_alive(5'b01111);
        step();
        chk("over_state", 32'(state), 32'd3);
        chk("over_play_en", 32'(play_en), 32'd0);
        chk("over_score", 32'(score), 32'h105);
        chk("over_hi", 32'(hi_score), 32'h105);
        set_alive(5'b11111);
        for (int j = 1; j <= 125; j++) begin
            step();
            chk($sformatf("over%0d_state", j), 32'(state), 32'd3);
            chk($sformatf("over%0d_rr", j), 32'(round_rst), 32'd0);
        end
        start_btn = 1'b0;
        step();
        chk("over_release_state", 32'(state), 32'd3);
        start_btn = 1'b1;
        step();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_rr", 32'(round_rst), 32'd1);
        chk("restart_score", 32'(score), 32'h000);
        chk("restart_hi", 32'(hi_score), 32'h105);
        start_btn = 1'b0;
        lives = 2'd2;
        step();
        chk("restart_rr_low", 32'(round_rst), 32'd0);
        chk("restart_state2", 32'(state), 32'd1);
        chk("restart_score2", 32'(score), 32'h000);
        model = 0;

        while (model + 13 <= 995) begin
            frame(5'b00000, 13);
            frame(5'b11111, 0);
        end
        while (model < 995) begin
            frame(5'b01111, 1);
            frame(5'b11111, 0);
        end
        chk("score_995", 32'(score), 32'h995);
        frame(5'b11101, 5);
        chk("score_sat", 32'(score), 32'h999);
        frame(5'b11111, 0);
        frame(5'b00000, 13);
        chk("score_sat_hold", 32'(score), 32'h999);
        frame(5'b11111, 0);

        // Asynchronous reset mid-frame clears everything at once.
        @(negedge v_sync);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_score", 32'(score), 32'h000);
        chk("arst_hi", 32'(hi_score), 32'h000);
        chk("arst_play_en", 32'(play_en), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Frame-rate game supervisor that sits directly downstream of the collision stage. It consumes the per-object alive flags and the lives count, and turns them into a play/hit/game-over state machine, a saturating 3-digit BCD score and a high score. It also issues a one-frame round-restart pulse that re-initialises the collision and motion stages. It advances once per frame and feeds the HUD/renderer.

## Interface
Parameters:
- MET_PTS, 4'd1: BCD points per meteor destroyed.
- STAR_PTS, 4'd5: BCD points per star collected.
- HIT_FRAMES, 6'd30: frames spent in HIT after a life is lost.
- OVER_FRAMES, 8'd120: minimum frames in OVER before a restart is accepted.

Ports:
- v_sync  in  1  frame clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_btn  in  1  level from the debouncer, already synchronous to v_sync.
- lives  in  2  remaining lives from the collision stage.
- m1_alive, m2_alive, m3_alive  in  1 each  meteor alive flags.
- s1_alive, s2_alive  in  1 each  star alive flags.
- state  out  2  0=IDLE, 1=PLAY, 2=HIT, 3=OVER.
- play_en  out  1  high in PLAY and HIT; gates ship/meteor motion.
- round_rst  out  1  one-frame pulse that restarts the collision and motion stages.
- flash  out  1  ship blink enable; toggles every 4 frames in HIT, 0 elsewhere.
- score  out  12  3-digit BCD {hundreds, tens, ones}.
- hi_score  out  12  3-digit BCD best score since reset.

## Operation
- On reset: state=IDLE, play_en=0, round_rst=0, flash=0, score=0, hi_score=0, all counters 0. Previous-value registers load 1 for each alive flag and 2'd2 for lives.
- Edge detection: each frame, register the alive flags and lives.
  - A meteor event is prev=1, now=0.
  - A star event is prev=1, now=0.
  - A hit event is lives < prev_lives.
  - Rising alive edges (regeneration) and lives increases (restart) are ignored.
- Scoring is active in PLAY and HIT only. The increment is (meteor events × MET_PTS) + (star events × STAR_PTS), all events from the same frame summed. Maximum per frame is 3+10=13.
- Score arithmetic is BCD add with decimal carry per digit. The result saturates at 12'h999 and never wraps.
- FSM transitions:
  - IDLE: rising edge of start_btn → PLAY. round_rst=1 in the frame the transition is registered. score cleared to 0 in the same frame.
  - PLAY: hit event with lives==0 → OVER. Hit event with lives>0 → HIT, hit counter loaded with HIT_FRAMES.
  - HIT: counter decrements each frame; reaching 0 → PLAY. Hit event with lives==0 → OVER immediately. A further hit event with lives>0 reloads the counter.
  - OVER: on entry, hi_score ← score if score > hi_score (unsigned compare of the BCD value is valid). over counter loaded with OVER_FRAMES and decrements to 0. When the counter is 0, a start_btn rising edge → PLAY, with round_rst and score clear as in IDLE.
- start_btn edge detection: prev_btn register. A button held through the OVER timeout does not restart; a new rising edge is required.
- flash: a free-running 2-bit sub-counter cleared on HIT entry. flash toggles when it wraps. flash is forced 0 outside HIT.
- Precedence within a frame: rst > game-over (lives==0) > hit > scoring. Scoring events in the same frame as the game-over transition are still counted before hi_score capture.

## Timing
- All outputs are registered; latency is 1 frame from an input change to the corresponding output update.
- round_rst is high for exactly one frame. The following frame, the collision stage re-initialises: lives go back to 2 and all alive flags to 1. These produce no events.
- hi_score capture uses the score value that includes the same-frame increment, i.e. the computed next score.
- Asynchronous rst mid-game returns to IDLE immediately. hi_score is cleared as well; no retention across rst.

## Test plan
- rst released, no start → state=0, score=0, play_en=0, round_rst=0 for 10 frames.
- start_btn rises → next frame state=1, round_rst=1 for one frame only; play_en=1.
- m1_alive 1→0 and s2_alive 1→0 in the same frame, score=12'h098 → score=12'h104 one frame later.
- Score 12'h995, star event → score=12'h999; further events leave it at 12'h999.
- lives 2→1 → state=2 for 30 frames with flash toggling every 4 frames, then state=1 and flash=0. Next, lives 1→0 → state=3 and hi_score=score.
- In OVER, start_btn held from entry through frame 120 → no restart. A release then a new press after the counter expires → state=1 and round_rst pulse.
